// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: result-source selects,
// forwarding mux selects and data-memory wait FSM states.
package hazard_ctrl_pkg;

  // Execute-stage result source; only RES_LOAD matters for load-use detection
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } resultSrc_t;

  // Execute operand mux selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // Data-memory wait FSM
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10
  } memState_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter clocked on the falling edge, like the pipeline
// registers it observes. Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: operand forwarding into
// Execute, load-use and branch stall/flush, a data-memory wait FSM with a
// timeout watchdog, and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       write_addrE,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       write_addrM,
  input  logic             RegWriteM,
  input  logic [4:0]       write_addrW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wait counter only has to reach MEM_TIMEOUT (at most 255)
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  memState_t  state;
  logic [7:0] waitCnt;
  logic       lwStall;
  logic       memStall;

  // Forward from the youngest stage that writes rs; x0 is never forwarded
  function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                        input logic [4:0] addrM,
                                        input logic       wrM,
                                        input logic [4:0] addrW,
                                        input logic       wrW);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wrM && (addrM != 5'd0) && (addrM == rs)) begin
      sel = FWD_M;
    end else if (wrW && (addrW != 5'd0) && (addrW == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Execute operand mux selects
  always_comb begin
    ForwardAE = fwdSel(Rs1E, write_addrM, RegWriteM, write_addrW, RegWriteW);
    ForwardBE = fwdSel(Rs2E, write_addrM, RegWriteM, write_addrW, RegWriteW);
  end

  // Hazard detection and the stall/flush network; a memory stall freezes
  // everything and masks flushes so a held branch or load-use is re-seen later
  always_comb begin
    lwStall  = (ResultSrcE == RES_LOAD) && (write_addrE != 5'd0) &&
               ((Rs1D == write_addrE) || (Rs2D == write_addrE));
    memStall = (state == ST_HALT) || (mem_req_M && !mem_ready);
    StallE   = memStall;
    StallM   = memStall;
    FlushW   = memStall;
    StallF   = memStall || lwStall;
    StallD   = memStall || lwStall;
    FlushD   = !memStall && PCSrcE;
    FlushE   = !memStall && (lwStall || PCSrcE);
  end

  // Data-memory wait FSM with timeout watchdog; HALT is left only by reset
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      waitCnt <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req_M && !mem_ready) begin
            state   <= ST_WAIT;
            waitCnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          // A dropped request is treated like completion
          if (mem_ready || !mem_req_M) begin
            state   <= ST_RUN;
            waitCnt <= '0;
          end else if (waitCnt == TIMEOUT_CNT) begin
            state   <= ST_HALT;
            mem_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state   <= ST_RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .en    (StallF),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .en    (FlushE),
    .clr   (clr_cnt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters.
module tb_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sFD;
    logic       fD;
    logic       fE;
    logic       mS;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] write_addrE = '0, write_addrM = '0, write_addrW = '0;
  logic [1:0] ResultSrcE = '0;
  logic RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0;
  logic mem_req_M = 1'b0, mem_ready = 1'b0, clr_cnt = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, mem_err;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  int expStall = 0;
  int expFlush = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .write_addrE(write_addrE), .ResultSrcE(ResultSrcE),
    .write_addrM(write_addrM), .RegWriteM(RegWriteM),
    .write_addrW(write_addrW), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .clr_cnt(clr_cnt),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push the expectation, compare mid-cycle, then advance the counter model
  // across the falling edge where the DUT updates its state.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sFD, input logic fD, input logic fE,
                      input logic mS, input logic err);
    exp_t e;
    e = '{fa: fa, fb: fb, sFD: sFD, fD: fD, fE: fE, mS: mS, err: err};
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!reset) begin
      expStall = 0;
      expFlush = 0;
    end
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_ForwardAE"}, {30'd0, ForwardAE}, {30'd0, e.fa});
      chk({tag, "_ForwardBE"}, {30'd0, ForwardBE}, {30'd0, e.fb});
      chk({tag, "_StallF"}, {31'd0, StallF}, {31'd0, e.sFD});
      chk({tag, "_StallD"}, {31'd0, StallD}, {31'd0, e.sFD});
      chk({tag, "_FlushD"}, {31'd0, FlushD}, {31'd0, e.fD});
      chk({tag, "_FlushE"}, {31'd0, FlushE}, {31'd0, e.fE});
      chk({tag, "_StallE"}, {31'd0, StallE}, {31'd0, e.mS});
      chk({tag, "_StallM"}, {31'd0, StallM}, {31'd0, e.mS});
      chk({tag, "_FlushW"}, {31'd0, FlushW}, {31'd0, e.mS});
      chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, e.err});
      chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, 32'(expStall));
      chk({tag, "_flush_cnt"}, {28'd0, flush_cnt}, 32'(expFlush));
    end
    @(negedge clk);
    if (!reset || clr_cnt) begin
      expStall = 0;
      expFlush = 0;
    end else begin
      if (e.sFD && expStall != CNT_MAX) expStall++;
      if (e.fE && expFlush != CNT_MAX) expFlush++;
    end
    #1;
  endtask

  task automatic idleInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    write_addrE = '0; write_addrM = '0; write_addrW = '0;
    ResultSrcE = '0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    mem_req_M = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    step("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Forwarding priority
    Rs1E = 5'd5; Rs2E = 5'd3;
    RegWriteM = 1'b1; write_addrM = 5'd5; RegWriteW = 1'b1; write_addrW = 5'd5;
    step("fwdA_M", 2'b10, 2'b00, 0, 0, 0, 0, 0);
    RegWriteM = 1'b0;
    step("fwdA_W", 2'b01, 2'b00, 0, 0, 0, 0, 0);
    Rs1E = 5'd0; write_addrM = 5'd0; write_addrW = 5'd0; RegWriteM = 1'b1;
    step("fwdA_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    Rs2E = 5'd9; write_addrM = 5'd9; write_addrW = 5'd9;
    step("fwdB_M", 2'b00, 2'b10, 0, 0, 0, 0, 0);
    write_addrM = 5'd4;
    step("fwdB_W", 2'b00, 2'b01, 0, 0, 0, 0, 0);
    idleInputs();

    // Load-use
    ResultSrcE = 2'b01; write_addrE = 5'd7; Rs2D = 5'd7;
    step("lw_use", 2'b00, 2'b00, 1, 0, 1, 0, 0);
    write_addrE = 5'd0;
    step("lw_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    ResultSrcE = 2'b00; write_addrE = 5'd7; Rs1D = 5'd7;
    step("alu_nolw", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    idleInputs();

    // Branch, then branch masked by a memory stall
    PCSrcE = 1'b1;
    step("branch", 2'b00, 2'b00, 0, 1, 1, 0, 0);
    mem_req_M = 1'b1; mem_ready = 1'b0;
    step("branch_memstall", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    mem_ready = 1'b1;
    step("branch_release", 2'b00, 2'b00, 0, 1, 1, 0, 0);
    idleInputs();

    // Memory wait of three cycles, counters cleared first
    clr_cnt = 1'b1;
    step("clr", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    clr_cnt = 1'b0; mem_req_M = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("memwait", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    mem_ready = 1'b1;
    step("memwait_ready", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    idleInputs();
    step("memwait_after", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    chk("memwait_stall_cnt3", {28'd0, stall_cnt}, 32'd3);

    // Request dropped while waiting returns to RUN
    mem_req_M = 1'b1;
    step("drop_wait", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    mem_req_M = 1'b0;
    step("drop_release", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    mem_req_M = 1'b1; mem_ready = 1'b1;
    step("drop_run", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    idleInputs();

    // Timeout: MEM_TIMEOUT+1 stalled cycles before HALT
    mem_req_M = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TB_TIMEOUT + 1; i++) step("timeout_wait", 2'b00, 2'b00, 1, 0, 0, 1, 0);
    step("halt", 2'b00, 2'b00, 1, 0, 0, 1, 1);
    mem_ready = 1'b1; PCSrcE = 1'b1;
    ResultSrcE = 2'b01; write_addrE = 5'd3; Rs1D = 5'd3;
    step("halt_ignores", 2'b00, 2'b00, 1, 0, 0, 1, 1);
    mem_req_M = 1'b0;
    step("halt_hold", 2'b00, 2'b00, 1, 0, 0, 1, 1);
    idleInputs();
    reset = 1'b0;
    step("halt_reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b1;
    mem_req_M = 1'b1; mem_ready = 1'b1;
    step("post_reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    idleInputs();

    // Counter saturation under a held load-use
    ResultSrcE = 2'b01; write_addrE = 5'd7; Rs2D = 5'd7;
    for (int i = 0; i < 20; i++) step("sat", 2'b00, 2'b00, 1, 0, 1, 0, 0);
    chk("sat_stall_cnt15", {28'd0, stall_cnt}, 32'd15);
    clr_cnt = 1'b1;
    step("sat_clr", 2'b00, 2'b00, 1, 0, 1, 0, 0);
    idleInputs();
    step("sat_cleared", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    chk("cleared_flush_cnt0", {28'd0, flush_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer-side partner of the Decode-to-Execute pipeline register.
- Reads the Execute-stage fields that register delivers (Rs1E, Rs2E, write_addrE, ResultSrcE) plus Memory and Writeback destination info.
- Drives the stall, flush and forwarding controls back into the pipeline registers and the Execute-stage operand muxes.
- Contains a data-memory wait FSM with a timeout watchdog and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, number of WAIT cycles without mem_ready before the core halts (valid range 2..255).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  core clock; all state updates on the falling edge, matching the pipeline registers.
reset  in  1  asynchronous, active-low reset.
Rs1D  in  5  rs1 of the instruction in Decode.
Rs2D  in  5  rs2 of the instruction in Decode.
Rs1E  in  5  rs1 of the instruction in Execute.
Rs2E  in  5  rs2 of the instruction in Execute.
write_addrE  in  5  destination register in Execute.
ResultSrcE  in  2  result select in Execute; 2'b01 = load.
write_addrM  in  5  destination register in Memory.
RegWriteM  in  1  Memory-stage register write enable.
write_addrW  in  5  destination register in Writeback.
RegWriteW  in  1  Writeback-stage register write enable.
PCSrcE  in  1  taken branch or jump resolved in Execute.
mem_req_M  in  1  load or store active in Memory.
mem_ready  in  1  data memory has completed the access.
clr_cnt  in  1  synchronous clear of the performance counters.
ForwardAE  out  2  operand A select: 00 = register file, 10 = from M, 01 = from W.
ForwardBE  out  2  operand B select; same encoding as ForwardAE.
StallF  out  1  hold PC.
StallD  out  1  hold the Fetch-to-Decode register.
FlushD  out  1  clear the Fetch-to-Decode register.
FlushE  out  1  clear the Decode-to-Execute register.
StallE  out  1  hold the Decode-to-Execute register.
StallM  out  1  hold the Execute-to-Memory register.
FlushW  out  1  clear the Memory-to-Writeback register (bubble).
mem_err  out  1  sticky flag: a memory timeout occurred.
stall_cnt  out  CNT_W  number of cycles with StallF asserted.
flush_cnt  out  CNT_W  number of cycles with FlushE asserted.

Behaviour:
- Reset (asynchronous, reset=0):
  - FSM goes to RUN; wait counter = 0; mem_err = 0; stall_cnt = 0; flush_cnt = 0.
  - All control outputs evaluate to 0.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & write_addrM != 0 & write_addrM == Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW & write_addrW != 0 & write_addrW == Rs1E.
  - Otherwise ForwardAE = 00.
  - M takes priority over W. ForwardBE is identical using Rs2E.
  - Register x0 is never forwarded.
- Load-use detect: lwStall = (ResultSrcE == 01) & write_addrE != 0 & (Rs1D == write_addrE | Rs2D == write_addrE).
- Memory stall: memStall = (state == HALT) | (state != HALT & mem_req_M & ~mem_ready).
- Output equations:
  - StallE = StallM = FlushW = memStall.
  - StallF = StallD = memStall | lwStall.
  - FlushD = ~memStall & PCSrcE.
  - FlushE = ~memStall & (lwStall | PCSrcE).
- Priority: memStall freezes every stage and suppresses all flushes. A branch or load-use held in Execute is re-evaluated after release.
- FSM states are RUN, WAIT, HALT. Transitions occur on the falling edge.
  - RUN: if mem_req_M & ~mem_ready, go to WAIT with counter = 1; else stay in RUN.
  - WAIT, mem_ready = 1: go to RUN with counter = 0. Stall is released in the same cycle mem_ready is high.
  - WAIT, mem_ready = 0 and counter == MEM_TIMEOUT: go to HALT and set mem_err = 1.
  - WAIT, otherwise: counter + 1.
  - WAIT, mem_req_M dropping (not expected): treat as ready and return to RUN.
  - HALT: all stages frozen; PCSrcE and lwStall are ignored. Only reset exits HALT.
  - Stall duration: an access whose mem_ready never rises stalls exactly MEM_TIMEOUT+1 cycles before HALT takes effect.
- Counters:
  - Each falling edge: stall_cnt + 1 if StallF; flush_cnt + 1 if FlushE.
  - Both saturate at all-ones with no wrap.
  - clr_cnt = 1 zeroes both counters that edge and takes precedence over increment.
- Reset mid-WAIT or in HALT: immediate return to RUN; counters and mem_err cleared.

Decomposition:
- Shared package: ResultSrc encodings (RES_ALU = 00, RES_LOAD = 01, RES_PC4 = 10), Forward encodings (FWD_RF, FWD_M, FWD_W), FSM state constants.
- One sub-module: sat_counter (CNT_W, en, clr), instantiated twice for the performance counters.
- Forwarding, hazard and FSM logic stay in hazard_ctrl.

Test Plan:
- Forward priority: Rs1E = 5, RegWriteM = 1 with write_addrM = 5, RegWriteW = 1 with write_addrW = 5 -> ForwardAE = 10. Set RegWriteM = 0 -> 01. Set Rs1E = 0 with both writing x0 -> 00.
- Load-use: ResultSrcE = 01, write_addrE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 and FlushD = 0 for one cycle. Same with write_addrE = 0 -> all 0.
- Branch: PCSrcE = 1 with no memory access -> FlushD = FlushE = 1. Add mem_req_M = 1, mem_ready = 0 -> FlushD = FlushE = 0 and StallF/D/E/M = FlushW = 1.
- Memory wait: mem_req_M = 1, mem_ready low for 3 cycles then high -> stalls held 3 cycles, released in the mem_ready cycle, state back to RUN, mem_err = 0, stall_cnt = 3.
- Timeout: MEM_TIMEOUT = 4, mem_ready stuck at 0 -> HALT after 5 stalled cycles, mem_err = 1, stalls stay high. Pulse reset = 0 -> everything returns to 0.
- Counter saturation: CNT_W = 4, hold lwStall for 20 cycles -> stall_cnt stops at 15. Pulse clr_cnt -> 0 on the next edge.
